// File: rtl/ps2_dir_decoder_if.sv
// rtl/ps2_dir_decoder_if.sv - PS/2 line inputs and decoded key pulse outputs
interface ps2_dir_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [3:0] direction;
  logic       start_pulse;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_dat,
    input  direction,
    input  start_pulse,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_dat,
    output direction,
    output start_pulse,
    output frame_err
  );
endinterface

// File: rtl/ps2_dir_decoder.sv
// rtl/ps2_dir_decoder.sv - PS/2 receiver decoding arrow keys and 's' into pulses
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of held keys.
module ps2_dir_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  ps2_dir_decoder_if.slave ps2
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  state_t        state_next;
  logic [2:0]    clk_sr;
  logic [1:0]    dat_sr;
  logic          fall;
  logic          dat_bit;
  logic [TW-1:0] idle_cnt;
  logic          timeout;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic          shift_en;
  logic          par_en;
  logic          clr_cnt;
  logic          accept;
  logic          err_now;
  logic          byte_valid;
  logic          frame_err_q;
  logic          ext;
  logic          brk;
  logic          is_prefix;
  logic [4:0]    key_hot;
  logic [4:0]    pass_mask;
  logic [4:0]    fire;
  logic [3:0]    direction_q;
  logic          start_q;

  // clk_sr[2] is the previous synchronized sample used for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sr <= 3'b111;
      dat_sr <= 2'b11;
    end else begin
      clk_sr <= {clk_sr[1:0], ps2.ps2_clk};
      dat_sr <= {dat_sr[0], ps2.ps2_dat};
    end
  end

  assign fall    = clk_sr[2] & ~clk_sr[1];
  assign dat_bit = dat_sr[1];
  assign timeout = (state != IDLE) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset || state == IDLE || fall) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall && !dat_bit) state_next = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (fall) state_next = STOP;
      STOP:    if (fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    clr_cnt  = 1'b0;
    accept   = 1'b0;
    err_now  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          if (dat_bit) err_now = 1'b1;
          else         clr_cnt = 1'b1;
        end
      end
      DATA:   shift_en = fall;
      PARITY: par_en   = fall;
      STOP: begin
        if (fall) begin
          // Odd parity: the nine received bits must hold an odd count of ones
          if (dat_bit && (^{shift_reg, par_bit})) accept  = 1'b1;
          else                                    err_now = 1'b1;
        end
      end
      default: ;
    endcase
    if (timeout) err_now = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'h00;
      par_bit     <= 1'b0;
      byte_valid  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_valid  <= accept;
      frame_err_q <= err_now;
      if (clr_cnt) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        shift_reg <= {dat_bit, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (par_en) par_bit <= dat_bit;
    end
  end

  assign is_prefix = (shift_reg == 8'hE0) || (shift_reg == 8'hF0);

  // key_hot bit 4 is 's', bits 3:0 follow the direction port ordering
  always_comb begin
    key_hot = 5'b00000;
    if (ext) begin
      case (shift_reg)
        8'h75:   key_hot = 5'b01000;
        8'h72:   key_hot = 5'b00100;
        8'h6B:   key_hot = 5'b00010;
        8'h74:   key_hot = 5'b00001;
        default: key_hot = 5'b00000;
      endcase
    end else if (shift_reg == 8'h1B) begin
      key_hot = 5'b10000;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [4:0] held;

  always_ff @(posedge clock) begin
    if (reset) begin
      held <= 5'b00000;
    end else if (byte_valid && !err_now && !is_prefix) begin
      if (brk) held <= held & ~key_hot;
      else     held <= held | key_hot;
    end
  end

  assign pass_mask = ~held;
`else
  assign pass_mask = 5'b11111;
`endif

  assign fire = key_hot & pass_mask;

  always_ff @(posedge clock) begin
    if (reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      direction_q <= 4'b0000;
      start_q     <= 1'b0;
    end else begin
      direction_q <= 4'b0000;
      start_q     <= 1'b0;
      if (err_now) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (shift_reg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          if (!brk) begin
            direction_q <= fire[3:0];
            start_q     <= fire[4];
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  assign ps2.direction   = direction_q;
  assign ps2.start_pulse = start_q;
  assign ps2.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// tb/tb_ps2_dir_decoder.sv - self-checking bench for ps2_dir_decoder
module tb_ps2_dir_decoder;

  localparam int TO   = 100;
  localparam int HALF = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ps2_dir_decoder_if bus();

  ps2_dir_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .ps2   (bus)
  );

  always #10 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Pulse counters observed every cycle outside reset
  int dir_cnt   = 0;
  int down_cnt  = 0;
  int start_cnt = 0;
  int err_cnt   = 0;
  int bad_cnt   = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.direction != 4'b0000) dir_cnt++;
      if (bus.direction == 4'b0100) down_cnt++;
      if (bus.start_pulse) start_cnt++;
      if (bus.frame_err) err_cnt++;
      if (!$onehot0(bus.direction) || (bus.direction != 4'b0000 && bus.start_pulse)) bad_cnt++;
    end
  end

  // Reference state: prefix flags and held-key mask
  logic       m_ext  = 1'b0;
  logic       m_brk  = 1'b0;
  logic [4:0] m_held = 5'b00000;

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    bus.ps2_dat = b;
    repeat (HALF) @(negedge clock);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clock);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic model(input logic [7:0] b, input bit ok,
                       output logic e, output logic [3:0] d, output logic s);
    logic [4:0] key;
    e = 1'b0; d = 4'b0000; s = 1'b0; key = 5'b00000;
    if (!ok) begin
      e = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (m_ext) begin
        if (b == 8'h75) key = 5'b01000;
        if (b == 8'h72) key = 5'b00100;
        if (b == 8'h6B) key = 5'b00010;
        if (b == 8'h74) key = 5'b00001;
      end else if (b == 8'h1B) begin
        key = 5'b10000;
      end
      if (m_brk) begin
        m_held = m_held & ~key;
      end else if ((key & m_held) == 5'b00000) begin
        {s, d} = key;
`ifdef PS2_TYPEMATIC_FILTER_EN
        m_held = m_held | key;
`endif
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // Samples k after the stop-bit clock fall: fall seen at 2, frame_err at 3, pulse at 4, idle at 5
  task automatic frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic       par;
    logic       e3, ee, es, s4;
    logic [3:0] d4, ed;
    logic [4:0] z3, z5;
    par = (~^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    @(negedge clock);
    bus.ps2_dat = ~bad_stop;
    repeat (HALF) @(negedge clock);
    bus.ps2_clk = 1'b0;
    repeat (2) @(negedge clock);
    @(negedge clock); e3 = bus.frame_err; z3 = {bus.start_pulse, bus.direction};
    @(negedge clock); d4 = bus.direction; s4 = bus.start_pulse;
    @(negedge clock); z5 = {bus.start_pulse, bus.direction, bus.frame_err};
    repeat (HALF - 5) @(negedge clock);
    bus.ps2_clk = 1'b1;
    repeat (HALF) @(negedge clock);
    model(b, !(bad_par || bad_stop), ee, ed, es);
    check(tag, "frame_err", e3, ee);
    check(tag, "early", z3, 0);
    check(tag, "direction", d4, ed);
    check(tag, "start", s4, es);
    check(tag, "after", z5, 0);
  endtask

  task automatic glitch(input string tag);
    logic e3;
    @(negedge clock);
    bus.ps2_dat = 1'b1;
    repeat (HALF) @(negedge clock);
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clock);
    e3 = bus.frame_err;
    repeat (HALF - 3) @(negedge clock);
    bus.ps2_clk = 1'b1;
    repeat (HALF) @(negedge clock);
    m_ext = 1'b0; m_brk = 1'b0;
    check(tag, "glitch_err", e3, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int         c0, c1, c2;
    logic [7:0] pool [7];
    logic [7:0] b;
    int         idx;

    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1B};
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;

    repeat (4) @(negedge clock);
    check("reset", "direction", bus.direction, 0);
    check("reset", "start", bus.start_pulse, 0);
    check("reset", "frame_err", bus.frame_err, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("release", "outputs", {bus.direction, bus.start_pulse, bus.frame_err}, 0);

    frame("up_pre", 8'hE0, 0, 0);
    frame("up", 8'h75, 0, 0);

    frame("s_make", 8'h1B, 0, 0);
    frame("s_brk_pre", 8'hF0, 0, 0);
    frame("s_brk", 8'h1B, 0, 0);
    frame("s_again", 8'h1B, 0, 0);
    frame("s_brk_pre2", 8'hF0, 0, 0);
    frame("s_brk2", 8'h1B, 0, 0);

    frame("left_badpar", 8'h6B, 1, 0);
    frame("left_pre", 8'hE0, 0, 0);
    frame("left", 8'h6B, 0, 0);

    frame("ext_badstop", 8'hE0, 0, 1);
    frame("no_ext", 8'h74, 0, 0);

    frame("glitch_pre", 8'hE0, 0, 0);
    glitch("glitch");
    frame("glitch_next", 8'h75, 0, 0);

    // Abandon a frame after four data bits and let it time out
    c0 = err_cnt;
    frame("to_pre", 8'hE0, 0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TO + 30) @(negedge clock);
    m_ext = 1'b0; m_brk = 1'b0;
    check("timeout", "err_pulses", err_cnt - c0, 1);
    frame("to_pre2", 8'hE0, 0, 0);
    frame("to_right", 8'h74, 0, 0);

    // Typematic repeats followed by the break sequence
    c0 = down_cnt;
    for (int i = 0; i < 3; i++) begin
      frame("rep_pre", 8'hE0, 0, 0);
      frame("rep", 8'h72, 0, 0);
    end
    frame("rep_bpre", 8'hE0, 0, 0);
    frame("rep_bf0", 8'hF0, 0, 0);
    frame("rep_brk", 8'h72, 0, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("typematic", "down_pulses", down_cnt - c0, 1);
`else
    check("typematic", "down_pulses", down_cnt - c0, 3);
`endif

    // One-cycle reset in the middle of an E0 frame
    c0 = err_cnt; c1 = dir_cnt; c2 = start_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_held = 5'b00000;
    check("midreset", "outputs", {bus.direction, bus.start_pulse, bus.frame_err}, 0);
    repeat (TO + 30) @(negedge clock);
    check("midreset", "err_pulses", err_cnt - c0, 0);
    check("midreset", "pulses", (dir_cnt - c1) + (start_cnt - c2), 0);
    frame("mr_pre", 8'hE0, 0, 0);
    frame("mr_up", 8'h75, 0, 0);

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 7);
      if (idx == 7) b = 8'($urandom);
      else          b = pool[idx];
      if ($urandom_range(0, 14) == 0) glitch("rnd_glitch");
      frame("rnd", b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    check("overall", "onehot_exclusive", bad_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
